// File: rtl/demux_1to3_reg.sv
// ---------------------------------------------------------------------------
// demux_1to3_reg
//
// Routes one input word to one of three output channels. Each output channel
// is a one-entry register slice with valid/ready handshaking. A select value
// of 2'b11 is invalid. Words sent with that select are dropped, and a
// saturating 8-bit error counter records each one.
//
// Ports
//   clk                   rising-edge clock
//   rst_n                 asynchronous active-low reset
//   in_data  [DATA_W-1:0] word to route
//   in_sel   [1:0]        00 -> a, 01 -> b, 10 -> c, 11 -> invalid (dropped)
//   in_valid              input word/select are valid
//   in_ready              block accepts the input this cycle (combinational)
//   a/b/c_data            registered channel data
//   a/b/c_valid           channel holds a word
//   a/b/c_ready           consumer takes the channel word this cycle
//   err_cnt  [7:0]        saturating count of words dropped for in_sel = 11
// ---------------------------------------------------------------------------
module demux_1to3_reg #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic [1:0]        in_sel,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] a_data,
   output logic              a_valid,
   input  logic              a_ready,
   output logic [DATA_W-1:0] b_data,
   output logic              b_valid,
   input  logic              b_ready,
   output logic [DATA_W-1:0] c_data,
   output logic              c_valid,
   input  logic              c_ready,
   output logic [7:0]        err_cnt
);

   typedef enum logic {
      CH_EMPTY = 1'b0,
      CH_FULL  = 1'b1
   } chan_state_e;

   chan_state_e       state_q [3];
   chan_state_e       state_d [3];
   logic [DATA_W-1:0] data_q  [3];
   logic [DATA_W-1:0] data_d  [3];
   logic [7:0]        err_cnt_q;
   logic [7:0]        err_cnt_d;

   logic [2:0] chan_ready;
   logic [2:0] load;
   logic       drop;
   logic       in_ready_c;
   logic       in_xfer;

   assign chan_ready = {c_ready, b_ready, a_ready};

   // The selected channel can accept a word if it is empty or is draining
   // this cycle. In the second case, the new word replaces the old one on the
   // same edge, so no bubble appears. Invalid selects are always accepted so
   // that they can be counted and discarded. in_valid is deliberately not
   // used here.
   always_comb begin
      in_ready_c = 1'b1;
      case (in_sel)
         2'b00:   in_ready_c = (state_q[0] == CH_EMPTY) || chan_ready[0];
         2'b01:   in_ready_c = (state_q[1] == CH_EMPTY) || chan_ready[1];
         2'b10:   in_ready_c = (state_q[2] == CH_EMPTY) || chan_ready[2];
         default: in_ready_c = 1'b1;
      endcase
   end

   assign in_xfer = in_valid && in_ready_c;

   // Decode an accepted transfer into a one-hot channel load or a drop.
   // in_sel is only looked at when in_valid is high, so garbage on in_sel
   // during idle cycles cannot change any state.
   always_comb begin
      load = 3'b000;
      drop = 1'b0;
      if (in_xfer) begin
         case (in_sel)
            2'b00:   load[0] = 1'b1;
            2'b01:   load[1] = 1'b1;
            2'b10:   load[2] = 1'b1;
            default: drop    = 1'b1;
         endcase
      end
   end

   // Per-channel EMPTY/FULL next state. A load always wins over a drain,
   // which keeps the channel FULL with the new word. Data is never cleared on
   // drain. It simply holds its last loaded value while the channel is EMPTY.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         state_d[i] = state_q[i];
         data_d[i]  = data_q[i];
         case (state_q[i])
            CH_EMPTY: begin
               if (load[i]) begin
                  state_d[i] = CH_FULL;
                  data_d[i]  = in_data;
               end
            end
            CH_FULL: begin
               if (load[i]) begin
                  data_d[i] = in_data;
               end else if (chan_ready[i]) begin
                  state_d[i] = CH_EMPTY;
               end
            end
            default: state_d[i] = CH_EMPTY;
         endcase
      end
   end

   // Error counter counts dropped words and sticks at 255.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (drop && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   // State register. Reset empties every channel, discards held words and
   // clears the data and the counter immediately, without waiting for a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            state_q[i] <= CH_EMPTY;
            data_q[i]  <= '0;
         end
         err_cnt_q <= 8'd0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            state_q[i] <= state_d[i];
            data_q[i]  <= data_d[i];
         end
         err_cnt_q <= err_cnt_d;
      end
   end

   assign in_ready = in_ready_c;
   assign a_data   = data_q[0];
   assign b_data   = data_q[1];
   assign c_data   = data_q[2];
   assign a_valid  = (state_q[0] == CH_FULL);
   assign b_valid  = (state_q[1] == CH_FULL);
   assign c_valid  = (state_q[2] == CH_FULL);
   assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_demux_1to3_reg.sv
// ---------------------------------------------------------------------------
// tb_demux_1to3_reg
//
// Scoreboard bench for demux_1to3_reg. The stimulus process keeps a small
// model of channel occupancy and of the error counter. Whenever the model
// says a word is accepted, the word is pushed onto that channel's expected
// queue. A separate monitor watches each channel on the falling edge. It
// checks that valid agrees with the model, that presented data matches the
// head of the queue while it waits, and it pops the queue on every output
// transfer.
// ---------------------------------------------------------------------------
module tb_demux_1to3_reg;

   logic        clk;
   logic        rst_n;
   logic [31:0] in_data;
   logic [1:0]  in_sel;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a_data, b_data, c_data;
   logic        a_valid, b_valid, c_valid;
   logic        a_ready, b_ready, c_ready;
   logic [7:0]  err_cnt;

   int compared   = 0;
   int mismatched = 0;

   logic [31:0] exp_a[$];
   logic [31:0] exp_b[$];
   logic [31:0] exp_c[$];
   logic        model_full[3];
   int          err_model;

   demux_1to3_reg #(.DATA_W(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .in_sel   (in_sel),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a_data   (a_data),
      .a_valid  (a_valid),
      .a_ready  (a_ready),
      .b_data   (b_data),
      .b_valid  (b_valid),
      .b_ready  (b_ready),
      .c_data   (c_data),
      .c_valid  (c_valid),
      .c_ready  (c_ready),
      .err_cnt  (err_cnt)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run always ends even if something stalls.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Drive one cycle of input starting just after a rising edge. At the
   // falling edge, check in_ready against the model and record any accepted
   // word. At the rising edge, advance the model.
   task automatic applyStimulus(input logic v, input logic [1:0] sel,
                                input logic [31:0] d, input logic ra,
                                input logic rb, input logic rc);
      logic       exp_rdy;
      logic       xfer;
      logic [2:0] rdy;
      in_valid = v;
      in_sel   = sel;
      in_data  = d;
      a_ready  = ra;
      b_ready  = rb;
      c_ready  = rc;
      rdy      = {rc, rb, ra};
      @(negedge clk);
      case (sel)
         2'd0:    exp_rdy = !model_full[0] || ra;
         2'd1:    exp_rdy = !model_full[1] || rb;
         2'd2:    exp_rdy = !model_full[2] || rc;
         default: exp_rdy = 1'b1;
      endcase
      checkOutput("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      xfer = v && exp_rdy && rst_n;
      if (xfer) begin
         case (sel)
            2'd0:    exp_a.push_back(d);
            2'd1:    exp_b.push_back(d);
            2'd2:    exp_c.push_back(d);
            default: ;
         endcase
      end
      @(posedge clk);
      if (rst_n) begin
         for (int i = 0; i < 3; i++) begin
            if (xfer && (int'(sel) == i))   model_full[i] = 1'b1;
            else if (model_full[i] && rdy[i]) model_full[i] = 1'b0;
         end
         if (xfer && (sel == 2'd3) && (err_model < 255)) err_model++;
      end
      #1;
   endtask

   // Check one channel on a falling edge against the model and its queue.
   task automatic checkChannel(input int idx, input logic v, input logic r,
                               input logic [31:0] d);
      int          sz;
      logic [31:0] front;
      front = '0;
      case (idx)
         0:       begin sz = exp_a.size(); if (sz > 0) front = exp_a[0]; end
         1:       begin sz = exp_b.size(); if (sz > 0) front = exp_b[0]; end
         default: begin sz = exp_c.size(); if (sz > 0) front = exp_c[0]; end
      endcase
      checkOutput($sformatf("ch%0d_valid", idx), {31'd0, v},
                  {31'd0, model_full[idx]});
      if (v) begin
         compared++;
         if (sz == 0) begin
            mismatched++;
            $display("[TB] FAIL ch%0d_unexpected: got word %h expected none", idx, d);
         end else begin
            if (d !== front) begin
               mismatched++;
               $display("[TB] FAIL ch%0d_data: got %h expected %h", idx, d, front);
            end
            if (r) begin
               case (idx)
                  0:       void'(exp_a.pop_front());
                  1:       void'(exp_b.pop_front());
                  default: void'(exp_c.pop_front());
               endcase
            end
         end
      end
   endtask

   // Monitor: independent of stimulus, compares every channel each cycle.
   initial begin
      forever begin
         @(negedge clk);
         checkChannel(0, a_valid, a_ready, a_data);
         checkChannel(1, b_valid, b_ready, b_data);
         checkChannel(2, c_valid, c_ready, c_data);
      end
   end

   // Main directed sequence.
   initial begin
      rst_n     = 1'b0;
      in_data   = '0;
      in_sel    = 2'd0;
      in_valid  = 1'b0;
      a_ready   = 1'b1;
      b_ready   = 1'b1;
      c_ready   = 1'b1;
      err_model = 0;
      for (int i = 0; i < 3; i++) model_full[i] = 1'b0;

      #1;
      checkOutput("rst_a_valid", {31'd0, a_valid}, 32'd0);
      checkOutput("rst_b_valid", {31'd0, b_valid}, 32'd0);
      checkOutput("rst_c_valid", {31'd0, c_valid}, 32'd0);
      checkOutput("rst_a_data", a_data, 32'd0);
      checkOutput("rst_b_data", b_data, 32'd0);
      checkOutput("rst_c_data", c_data, 32'd0);
      checkOutput("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
      checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Route one word to each channel with all consumers ready.
      applyStimulus(1'b1, 2'd0, 32'h11111111, 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 2'd1, 32'h22222222, 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 2'd2, 32'h33333333, 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b0, 2'd0, 32'h0,        1'b1, 1'b1, 1'b1);
      applyStimulus(1'b0, 2'd0, 32'h0,        1'b1, 1'b1, 1'b1);

      // Backpressure on a while b keeps flowing.
      applyStimulus(1'b1, 2'd0, 32'hAAAA0001, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b1, 2'd0, 32'hAAAA0002, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b1, 2'd1, 32'hBBBB0001, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b1, 2'd0, 32'hAAAA0002, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b1, 2'd0, 32'hAAAA0002, 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b0, 2'd0, 32'h0,        1'b1, 1'b1, 1'b1);
      applyStimulus(1'b0, 2'd0, 32'h0,        1'b1, 1'b1, 1'b1);

      // Simultaneous drain and load on a.
      applyStimulus(1'b1, 2'd0, 32'h00000005, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b1, 2'd0, 32'h00000006, 1'b1, 1'b1, 1'b1);
      checkOutput("simul_a_valid", {31'd0, a_valid}, 32'd1);
      checkOutput("simul_a_data", a_data, 32'h00000006);
      applyStimulus(1'b0, 2'd0, 32'h0,        1'b1, 1'b1, 1'b1);

      // Seven invalid words, then fill every channel and reset mid-cycle.
      for (int i = 0; i < 7; i++) applyStimulus(1'b1, 2'd3, 32'hDEAD0000 + i, 1'b1, 1'b1, 1'b1);
      checkOutput("err_cnt_7", {24'd0, err_cnt}, err_model);
      applyStimulus(1'b1, 2'd0, 32'hA1A1A1A1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'd1, 32'hB1B1B1B1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'd2, 32'hC1C1C1C1, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b0;
      #3;
      rst_n = 1'b0;
      exp_a.delete();
      exp_b.delete();
      exp_c.delete();
      for (int i = 0; i < 3; i++) model_full[i] = 1'b0;
      err_model = 0;
      #1;
      checkOutput("mid_rst_a_valid", {31'd0, a_valid}, 32'd0);
      checkOutput("mid_rst_b_valid", {31'd0, b_valid}, 32'd0);
      checkOutput("mid_rst_c_valid", {31'd0, c_valid}, 32'd0);
      checkOutput("mid_rst_a_data", a_data, 32'd0);
      checkOutput("mid_rst_b_data", b_data, 32'd0);
      checkOutput("mid_rst_c_data", c_data, 32'd0);
      checkOutput("mid_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
      @(posedge clk);
      #1;
      // Transfers attempted while in reset must have no effect.
      applyStimulus(1'b1, 2'd3, 32'h0BAD0BAD, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'd0, 32'h0BAD0BAD, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b0;
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("post_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
      // The first edges after reset behave normally.
      applyStimulus(1'b1, 2'd1, 32'h12345678, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 2'd0, 32'h0,        1'b1, 1'b1, 1'b1);
      applyStimulus(1'b0, 2'd0, 32'h0,        1'b1, 1'b1, 1'b1);

      // Flood of invalid selects saturates the counter at 255.
      for (int i = 0; i < 300; i++) applyStimulus(1'b1, 2'd3, $urandom, 1'b1, 1'b1, 1'b1);
      checkOutput("err_cnt_sat", {24'd0, err_cnt}, err_model);
      checkOutput("err_cnt_255", {24'd0, err_cnt}, 32'd255);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'd3, $urandom, 1'b1, 1'b1, 1'b1);
      checkOutput("err_cnt_hold", {24'd0, err_cnt}, 32'd255);

      applyStimulus(1'b0, 2'd0, 32'h0, 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b0, 2'd0, 32'h0, 1'b1, 1'b1, 1'b1);
      checkOutput("a_queue_left", exp_a.size(), 32'd0);
      checkOutput("b_queue_left", exp_b.size(), 32'd0);
      checkOutput("c_queue_left", exp_c.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
